// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb -- parametrised register file with issue/writeback scoreboard.
//
// Two combinational read ports and one synchronous write port. Register 0 can
// be hardwired to zero. A same-cycle writeback can be forwarded to the read
// ports. A per-register busy bit marks destinations between issue and
// writeback. The busy bit is used to flag read-after-write hazards to decode.
//
// Ports:
//   CLK          clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   rd_addr1/2   read port addresses
//   rd_data1/2   read port data (combinational)
//   wr_en        writeback enable
//   wr_addr      writeback address
//   wr_data      writeback data
//   iss_en       issue strobe, marks iss_addr busy
//   iss_addr     destination register of the issuing instruction
//   busy1/2      operand pending flags (combinational)
//   hazard       busy1 | busy2
//   busy_count   registered population count of the busy vector
// ----------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              busy1,
    output logic              busy2,
    output logic              hazard,
    output logic [ADDR_W:0]   busy_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_count;

    logic [DEPTH-1:0]  w_busy_next;
    logic [ADDR_W:0]   w_busy_pop;
    logic              w_wr_ok;

    // Writes to the hardwired zero register are dropped.
    assign w_wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == '0);

    // Scoreboard next state: issue beats writeback, because the new producer
    // supersedes the retiring one.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_busy_next = r_busy;
        w_busy_pop  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (iss_en && iss_addr == ADDR_W'(i)) begin
                w_busy_next[i] = 1'b1;
            end else if (wr_en && wr_addr == ADDR_W'(i)) begin
                w_busy_next[i] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            w_busy_next[0] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_busy_pop = w_busy_pop + (ADDR_W + 1)'(w_busy_next[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (reset) begin
            // NOTE: the register array is deliberately reset. The architecture
            // requires every register to read 0 after reset, and that costs
            // a reset path on every storage bit.
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[wr_addr] <= wr_data;
            end
            r_busy       <= w_busy_next;
            r_busy_count <= w_busy_pop;
        end
    end

    // Read port: the zero register has top priority. A forwarded writeback
    // comes next; it supplies the data and hides the busy flag it retires.
    // The stored value and busy bit are used otherwise.
    function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] data;
        logic              busy;
        data = r_regs[addr];
        busy = r_busy[addr];
        if (BYPASS != 0 && wr_en && wr_addr == addr) begin
            data = wr_data;
            busy = 1'b0;
        end
        if (ZERO_REG != 0 && addr == '0) begin
            data = '0;
            busy = 1'b0;
        end
        return {busy, data};
    endfunction

    logic [DATA_W:0] w_port1;
    logic [DATA_W:0] w_port2;

    assign w_port1    = read_port(rd_addr1);
    assign w_port2    = read_port(rd_addr2);
    assign rd_data1   = w_port1[DATA_W-1:0];
    assign rd_data2   = w_port2[DATA_W-1:0];
    assign busy1      = w_port1[DATA_W];
    assign busy2      = w_port2[DATA_W];
    assign hazard     = busy1 | busy2;
    assign busy_count = r_busy_count;

endmodule

// File: tb/tb_regfile_sb.sv
// ----------------------------------------------------------------------------
// tb_regfile_sb -- directed bench for regfile_sb.
//
// Instance "dut" uses the default parameters, with 32x32, a zero register and
// bypass. Instance "dut_nb" is an 8x16 file with no zero register and no
// bypass. The two instances share the clock and reset.
// ----------------------------------------------------------------------------
module tb_regfile_sb;

    logic CLK = 1'b0;
    logic reset;

    always #5 CLK = ~CLK;

    // Default instance signals.
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, iss_addr;
    logic [31:0] rd_data1, rd_data2, wr_data;
    logic        wr_en, iss_en, busy1, busy2, hazard;
    logic [5:0]  busy_count;

    // No-zero / no-bypass instance signals.
    logic [2:0]  n_rd_addr1, n_rd_addr2, n_wr_addr, n_iss_addr;
    logic [15:0] n_rd_data1, n_rd_data2, n_wr_data;
    logic        n_wr_en, n_iss_en, n_busy1, n_busy2, n_hazard;
    logic [3:0]  n_busy_count;

    int total = 0;
    int bad   = 0;

    regfile_sb dut (
        .CLK(CLK), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy1(busy1), .busy2(busy2), .hazard(hazard),
        .busy_count(busy_count)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .CLK(CLK), .reset(reset),
        .rd_addr1(n_rd_addr1), .rd_addr2(n_rd_addr2),
        .rd_data1(n_rd_data1), .rd_data2(n_rd_data2),
        .wr_en(n_wr_en), .wr_addr(n_wr_addr), .wr_data(n_wr_data),
        .iss_en(n_iss_en), .iss_addr(n_iss_addr),
        .busy1(n_busy1), .busy2(n_busy2), .hazard(n_hazard),
        .busy_count(n_busy_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge. Inputs change and outputs are sampled 1 ns
    // after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0; iss_en   = 1'b0;
        n_wr_en  = 1'b0; n_iss_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; iss_addr = '0; wr_data = '0;
        n_rd_addr1 = '0; n_rd_addr2 = '0; n_wr_addr = '0; n_iss_addr = '0; n_wr_data = '0;
        idle();
        step();
        step();
        reset = 1'b0;

        // 1. Reset state, then non-zero and zero writes to reg 5.
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a);
            rd_addr2 = 5'(31 - a);
            #1;
            check("rst_rd1", rd_data1, 0);
            check("rst_rd2", rd_data2, 0);
            check("rst_hazard", {busy1, busy2, hazard}, 0);
        end
        check("rst_count", busy_count, 0);

        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        step();
        idle(); rd_addr1 = 5'd5;
        #1 check("wr5_beef", rd_data1, 32'hDEAD_BEEF);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0;
        step();
        idle();
        #1 check("wr5_zero", rd_data1, 32'h0);
        check("wr_nonbusy_count", busy_count, 0);

        // 2. The zero register ignores writes and issues.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        iss_en = 1'b1; iss_addr = 5'd0;
        step();
        idle(); rd_addr1 = 5'd0;
        #1;
        check("zero_rd", rd_data1, 0);
        check("zero_busy", busy1, 0);
        check("zero_count", busy_count, 0);

        // 3. The bypass forwards a same-cycle write.
        rd_addr1 = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
        #1 check("byp_same_cycle", rd_data1, 32'hA5A5_A5A5);
        step();
        idle();
        #1 check("byp_after", rd_data1, 32'hA5A5_A5A5);

        // 4. Issue reg 3. The hazard appears next cycle and is masked by writeback.
        iss_en = 1'b1; iss_addr = 5'd3; rd_addr2 = 5'd3;
        #1 check("iss_not_yet", busy2, 0);
        step();
        idle();
        #1;
        check("iss3_busy2", busy2, 1);
        check("iss3_hazard", hazard, 1);
        check("iss3_count", busy_count, 1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1;
        check("wb3_busy2_masked", busy2, 0);
        check("wb3_hazard", hazard, 0);
        check("wb3_fwd", rd_data2, 32'h33);
        step();
        idle();
        #1;
        check("wb3_count", busy_count, 0);
        check("wb3_busy2_after", busy2, 0);

        // 5. Issue and writeback to busy reg 9 in the same cycle: the issue wins.
        iss_en = 1'b1; iss_addr = 5'd9;
        step();
        iss_en = 1'b1; iss_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        step();
        idle(); rd_addr1 = 5'd9;
        #1;
        check("same9_data", rd_data1, 32'h99);
        check("same9_busy", busy1, 1);
        check("same9_count", busy_count, 1);
        iss_en = 1'b1; iss_addr = 5'd9;
        step();
        idle();
        #1 check("reissue9_count", busy_count, 1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h999;
        step();
        idle();
        #1 check("retire9_count", busy_count, 0);

        // 6. Issue regs 1, 2 and 4, then reset together with a write.
        iss_en = 1'b1; iss_addr = 5'd1; step();
        iss_addr = 5'd2; step();
        iss_addr = 5'd4; step();
        idle(); rd_addr1 = 5'd1; rd_addr2 = 5'd2;
        #1;
        check("three_count", busy_count, 3);
        check("three_busy", {busy1, busy2, hazard}, 3'b111);
        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hFFFF_FFFF;
        step();
        reset = 1'b0; idle();
        #1;
        check("rst2_count", busy_count, 0);
        check("rst2_busy", {busy1, busy2}, 0);
        check("rst2_rd1", rd_data1, 0);
        foreach (wr_data[i]) begin end
        rd_addr1 = 5'd4; rd_addr2 = 5'd9;
        #1 check("rst2_rd4_rd9", {rd_data1, rd_data2}, 0);
        rd_addr1 = 5'd7; rd_addr2 = 5'd5;
        #1 check("rst2_rd7_rd5", {rd_data1, rd_data2}, 0);

        // 7. No zero register and no bypass, on the 8-entry instance.
        n_rd_addr1 = 3'd0;
        n_wr_en = 1'b1; n_wr_addr = 3'd0; n_wr_data = 16'h1234;
        #1 check("nb_old_value", n_rd_data1, 0);
        step();
        idle();
        #1 check("nb_reg0_written", n_rd_data1, 16'h1234);

        n_iss_en = 1'b1; n_iss_addr = 3'd2; n_rd_addr2 = 3'd2;
        step();
        idle();
        n_wr_en = 1'b1; n_wr_addr = 3'd2; n_wr_data = 16'hBEEF;
        #1;
        check("nb_busy_unmasked", n_busy2, 1);
        check("nb_hazard", n_hazard, 1);
        check("nb_rd_old", n_rd_data2, 0);
        step();
        idle();
        #1;
        check("nb_retired", n_busy2, 0);
        check("nb_rd_new", n_rd_data2, 16'hBEEF);

        for (int r = 0; r < 8; r++) begin
            n_iss_en = 1'b1; n_iss_addr = 3'(r);
            step();
        end
        idle();
        #1 check("nb_full_count", n_busy_count, 8);
        n_iss_en = 1'b1; n_iss_addr = 3'd0;
        step();
        idle();
        #1 check("nb_no_wrap", n_busy_count, 8);
        n_iss_en = 1'b1; n_iss_addr = 3'd5;
        n_wr_en = 1'b1; n_wr_addr = 3'd5; n_wr_data = 16'h5555;
        step();
        idle(); n_rd_addr1 = 3'd5;
        #1;
        check("nb_same5_busy", n_busy1, 1);
        check("nb_same5_data", n_rd_data1, 16'h5555);
        check("nb_same5_count", n_busy_count, 8);
        n_wr_en = 1'b1; n_wr_addr = 3'd0; n_wr_data = 16'h0;
        step();
        idle(); n_rd_addr1 = 3'd0;
        #1;
        check("nb_reg0_retire", n_busy_count, 7);
        check("nb_reg0_zero_write", n_rd_data1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file for the pipelined CPU core, replacing the fixed 32x32 file.
- Adds configurable width and depth, an optional hardwired-zero register 0, and optional write-to-read bypass.
- Adds a per-register scoreboard (busy bits) that tracks in-flight destinations from issue until writeback and flags read-after-write hazards to the decode stage.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; depth = 2^ADDR_W.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never marked busy.
- BYPASS, 1, 1 = a same-cycle writeback is forwarded to the read ports and masks that register's busy flag.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data1  out  DATA_W  read port 1 data (combinational).
- rd_data2  out  DATA_W  read port 2 data (combinational).
- wr_en  in  1  writeback enable.
- wr_addr  in  ADDR_W  writeback address.
- wr_data  in  DATA_W  writeback data.
- iss_en  in  1  issue: mark iss_addr busy.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- busy1  out  1  operand 1 pending (combinational).
- busy2  out  1  operand 2 pending (combinational).
- hazard  out  1  busy1 OR busy2.
- busy_count  out  ADDR_W+1  registered count of busy registers.

Behaviour:
- Clock and reset: one clock, CLK. reset is synchronous and active-high. On a rising edge with reset=1:
  - all registers become 0;
  - all busy bits clear;
  - busy_count becomes 0.
  - reset overrides wr_en and iss_en in the same cycle.
- Outputs after reset: rd_data* = 0, busy* = 0, hazard = 0 (when wr_en=0).
- Write:
  - On a rising edge with wr_en=1, regs[wr_addr] <= wr_data.
  - Any value is written, including 0.
  - With ZERO_REG=1, writes to address 0 are discarded.
- Read: combinational, zero-cycle latency.
  - rd_dataN = regs[rd_addrN], or 0 if ZERO_REG=1 and rd_addrN=0.
  - With BYPASS=1, wr_en=1, wr_addr=rd_addrN and the address is not the zero register: rd_dataN = wr_data.
  - With BYPASS=0, the new value is visible the cycle after the write.
- Scoreboard: busy[i] next-state, evaluated per register at each rising edge:
  - set if iss_en=1 and iss_addr=i;
  - else cleared if wr_en=1 and wr_addr=i;
  - else hold.
  - Simultaneous issue and writeback to the same address: set wins (a new producer supersedes the retiring one); the data write still occurs.
  - Issue to an already-busy register: stays busy; busy_count does not increment.
  - Writeback to a non-busy register: data written, busy unchanged, no error.
  - ZERO_REG=1: busy[0] is held at 0 permanently.
- Busy outputs: busyN = busy[rd_addrN], forced to 0 if:
  - ZERO_REG=1 and rd_addrN=0; or
  - BYPASS=1, wr_en=1 and wr_addr=rd_addrN (value is being forwarded).
  - An iss_en in the current cycle does not affect busyN until the next cycle.
- hazard: combinational OR of busy1 and busy2.
  - The block does not gate iss_en on hazard; stalling is upstream's responsibility.
- busy_count:
  - Registered; equals the population count of the busy vector after each edge.
  - Maximum value 2^ADDR_W (2^ADDR_W-1 when ZERO_REG=1); no wrap.

Test Plan:
1. Reset, then read all addresses -> rd_data=0, busy=0, busy_count=0; write reg 5=0xDEADBEEF, then write reg 5=0 -> reg 5 reads 0 (zero writes are not dropped).
2. ZERO_REG=1: write reg 0=0x1234, issue iss_addr=0 -> reg 0 reads 0, busy stays 0, busy_count stays 0.
3. BYPASS=1, write reg 7=0xA5A5A5A5 with rd_addr1=7 in the same cycle -> rd_data1=0xA5A5A5A5 combinationally. Same with BYPASS=0 -> rd_data1 shows the old value, then the new value next cycle.
4. Issue reg 3 -> next cycle rd_addr2=3 gives busy2=1, hazard=1, busy_count=1; writeback reg 3 -> busy2=0 that cycle (BYPASS=1), busy_count=0 after the edge.
5. Same-cycle iss_en and wr_en to reg 9 while reg 9 is busy -> data written, busy[9] stays 1, busy_count unchanged.
6. Issue regs 1, 2, 4 on successive cycles, then assert reset together with wr_en to reg 1 -> all registers 0, busy_count=0, write ignored.
